lsu_ctrl: RTL and testbench

// - Load/store initiator between the core execute stage and the word-wide data ram.
// - Takes RV32I byte/half/word load-store requests. Drives ram address/data_in/store/load.
// - Returns sign- or zero-extended load data.
// - Implements SB/SH as a read-modify-write, because the ram accepts only full 32-bit words.

---
 rtl/lsu_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute stage and a word-wide data ram; SB/SH are done as read-modify-write.
// Optional feature: define LSU_RANGE_CHECK_EN to reject addresses above the ram's byte range.
module lsu_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_done,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic              mem_store,
    output logic              mem_load,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W+1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wword_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              req_err;
    logic              accept;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = old_word;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Every rejection is decided from the live request fields in the accept cycle.
    always_comb begin
        req_err = 1'b0;
        if (req_load == req_store)
            req_err = 1'b1;
        if (req_load && (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11))
            req_err = 1'b1;
        if (req_store && (req_funct3[2] || req_funct3[1:0] == 2'b11))
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`ifdef LSU_RANGE_CHECK_EN
        if (|req_addr[31:ADDR_W+2])
            req_err = 1'b1;
`endif
    end

`ifndef LSU_RANGE_CHECK_EN
    logic unused_upper_addr;
    assign unused_upper_addr = ^req_addr[31:ADDR_W+2];
`endif

    assign accept    = req_valid && (state == IDLE);
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_next;
            if (accept)
                err_q <= req_err;
            if (state == RD)
                rdata_q <= load_extend(mem_data_out, funct3_q, addr_q[1:0]);
        end
    end

    // Datapath registers need no reset: every output they feed is gated by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= req_addr[ADDR_W+1:0];
            funct3_q <= req_funct3;
            wword_q  <= req_wdata;
        end else if (state == RMW_RD) begin
            wword_q <= store_merge(mem_data_out, wword_q, funct3_q[1:0], addr_q[1:0]);
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        rsp_done    = 1'b0;
        rsp_err     = 1'b0;
        mem_load    = 1'b0;
        mem_store   = 1'b0;
        mem_address = '0;
        mem_data_in = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (req_load)
                        state_next = RD;
                    else if (req_funct3[1:0] == 2'b10)
                        state_next = WR;
                    else
                        state_next = RMW_RD;
                end
            end
            RD: begin
                mem_load    = 1'b1;
                mem_address = addr_q[ADDR_W+1:2];
                state_next  = RESP;
            end
            RMW_RD: begin
                mem_load    = 1'b1;
                mem_address = addr_q[ADDR_W+1:2];
                state_next  = WR;
            end
            WR: begin
                mem_store   = 1'b1;
                mem_address = addr_q[ADDR_W+1:2];
                mem_data_in = wword_q;
                state_next  = RESP;
            end
            RESP: begin
                rsp_done   = 1'b1;
                rsp_err    = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: bench-side ram, byte-level reference model, directed literal checks and random traffic.
module tb_lsu_ctrl;
    localparam int ADDR_W = 12;
    localparam int NWORDS = 2 ** ADDR_W;
    localparam int NBYTES = 4 * NWORDS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_load = 1'b0;
    logic              req_store = 1'b0;
    logic [2:0]        req_funct3 = 3'b0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_done;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic              mem_store;
    logic              mem_load;
    logic [31:0]       mem_data_out;

    logic [31:0] ram    [0:NWORDS-1];
    logic [7:0]  mbytes [0:NBYTES-1];
    logic [31:0] exp_rdata = 32'h0;
    bit          mon_en = 1'b0;
    int          tests = 0;
    int          fails = 0;

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_store(mem_store), .mem_load(mem_load), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_store) ram[mem_address] <= mem_data_in;
    assign mem_data_out = mem_load ? ram[mem_address] : 32'hA5A5_A5A5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("ld_st_exclusive", 32'(mem_load & mem_store), 32'h0);
            if (req_ready)
                check("idle_outputs", 32'({mem_load, mem_store, rsp_done, mem_address}), 32'h0);
        end
    end

    function automatic bit model_err(input logic ld, input logic st, input logic [2:0] f3,
                                     input logic [31:0] a);
        bit e;
        e = (ld == st);
        if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) e = 1'b1;
        if (st && f3 > 2) e = 1'b1;
        if ((f3 == 1 || f3 == 5) && (a % 2) != 0) e = 1'b1;
        if (f3 == 2 && (a % 4) != 0) e = 1'b1;
`ifdef LSU_RANGE_CHECK_EN
        if (a >= NBYTES) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic int model_size(input logic [2:0] f3);
        if (f3 == 0 || f3 == 4) return 1;
        if (f3 == 1 || f3 == 5) return 2;
        return 4;
    endfunction

    task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input string tag,
                          output logic got_err, output logic [31:0] got_rdata, output int got_lat);
        bit          e;
        bit          done;
        int          sz, ba, wa, exp_lat, nld, nst, loads, stores, n;
        logic [31:0] v;
        logic [31:0] exp_wword;
        e  = model_err(ld, st, f3, a);
        sz = model_size(f3);
        ba = int'(a % NBYTES);
        wa = ba / 4;
        exp_wword = 32'h0;
        if (!e && ld) begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v = v | (32'(mbytes[ba+i]) << (8 * i));
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 32'h1);
            exp_rdata = v;
        end
        if (!e && st) begin
            for (int i = 0; i < sz; i++) mbytes[ba+i] = 8'(wd >> (8 * i));
            exp_wword = {mbytes[wa*4+3], mbytes[wa*4+2], mbytes[wa*4+1], mbytes[wa*4]};
        end
        exp_lat = e ? 1 : (ld ? 2 : (sz == 4 ? 2 : 3));
        nld     = e ? 0 : (ld ? 1 : (sz == 4 ? 0 : 1));
        nst     = (!e && st) ? 1 : 0;

        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        req_load = ld; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'h1);
        @(posedge clk);
        got_lat = 0; loads = 0; stores = 0; got_err = 1'b0; got_rdata = 32'h0; done = 1'b0;
        while (!done && got_lat < 8) begin
            got_lat++;
            @(negedge clk);
            if (mem_load) begin
                loads++;
                check({tag, "_ld_addr"}, 32'(mem_address), 32'(wa));
            end
            if (mem_store) begin
                stores++;
                check({tag, "_st_addr"}, 32'(mem_address), 32'(wa));
                check({tag, "_st_data"}, mem_data_in, exp_wword);
            end
            if (rsp_done) begin
                done = 1'b1;
                got_err = rsp_err;
                got_rdata = rsp_rdata;
            end else begin
                @(posedge clk);
            end
        end
        if (!done) check({tag, "_timeout"}, 32'h0, 32'h1);
        check({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(got_err), 32'(e));
        check({tag, "_rdata"}, got_rdata, exp_rdata);
        check({tag, "_nload"}, 32'(loads), 32'(nld));
        check({tag, "_nstore"}, 32'(stores), 32'(nst));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_after"}, 32'({req_ready, rsp_done}), 32'h2);
        check({tag, "_hold"}, rsp_rdata, exp_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        er;
        logic [31:0] rd;
        int          lat;
        int          mism;
        logic [2:0]  ld_set [5];
        logic [2:0]  st_set [3];
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel, sz;

        ld_set[0] = 3'd0; ld_set[1] = 3'd1; ld_set[2] = 3'd2; ld_set[3] = 3'd4; ld_set[4] = 3'd5;
        st_set[0] = 3'd0; st_set[1] = 3'd1; st_set[2] = 3'd2;
        for (int i = 0; i < NWORDS; i++) ram[i] = 32'h0;
        for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h0;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'({req_ready, rsp_done, rsp_err, mem_store, mem_load}), 32'h10);
        check("reset_rdata", rsp_rdata, 32'h0);
        check("reset_mem_outs", mem_data_in | 32'(mem_address), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10", er, rd, lat);
        check("sw10_lit_lat", 32'(lat), 32'd2);
        check("sw10_lit_ram", ram[4], 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "lw10", er, rd, lat);
        check("lw10_lit", rd, 32'hDEADBEEF);
        check("lw10_lit_lat", 32'(lat), 32'd2);
        do_req(1'b0, 1'b1, 3'd0, 32'h12, 32'h55, "sb12", er, rd, lat);
        check("sb12_lit_lat", 32'(lat), 32'd3);
        do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "lw10b", er, rd, lat);
        check("sb12_lit_word", rd, 32'hDE55BEEF);

        do_req(1'b0, 1'b1, 3'd2, 32'h20, 32'h0080FF7F, "sw20", er, rd, lat);
        do_req(1'b1, 1'b0, 3'd0, 32'h20, 32'h0, "lb20", er, rd, lat);
        check("lb20_lit", rd, 32'h0000007F);
        do_req(1'b1, 1'b0, 3'd0, 32'h21, 32'h0, "lb21", er, rd, lat);
        check("lb21_lit", rd, 32'hFFFFFFFF);
        do_req(1'b1, 1'b0, 3'd4, 32'h21, 32'h0, "lbu21", er, rd, lat);
        check("lbu21_lit", rd, 32'h000000FF);
        do_req(1'b1, 1'b0, 3'd1, 32'h22, 32'h0, "lh22", er, rd, lat);
        check("lh22_lit", rd, 32'h00000080);
        do_req(1'b1, 1'b0, 3'd5, 32'h20, 32'h0, "lhu20", er, rd, lat);
        check("lhu20_lit", rd, 32'h0000FF7F);

        do_req(1'b1, 1'b0, 3'd1, 32'h03, 32'h0, "err_lh03", er, rd, lat);
        check("err_lh03_lit", 32'({er, 4'(lat)}), 32'h11);
        do_req(1'b0, 1'b1, 3'd2, 32'h06, 32'h1111_2222, "err_sw06", er, rd, lat);
        check("err_sw06_lit", 32'({er, 4'(lat)}), 32'h11);
        do_req(1'b1, 1'b0, 3'd3, 32'h10, 32'h0, "err_f3", er, rd, lat);
        check("err_f3_lit", 32'({er, 4'(lat)}), 32'h11);
        do_req(1'b1, 1'b1, 3'd2, 32'h10, 32'h3333_4444, "err_ldst", er, rd, lat);
        check("err_ldst_lit", 32'({er, 4'(lat)}), 32'h11);
        check("err_mem_kept", ram[4], 32'hDE55BEEF);
        check("err_rdata_kept", rsp_rdata, 32'h0000FF7F);

        do_req(1'b0, 1'b1, 3'd2, 32'h0000_4000, 32'h1234_5678, "sw4000", er, rd, lat);
`ifdef LSU_RANGE_CHECK_EN
        check("range_err_lit", 32'(er), 32'h1);
        check("range_ram0_lit", ram[0], 32'h0);
`else
        check("alias_err_lit", 32'(er), 32'h0);
        check("alias_ram0_lit", ram[0], 32'h1234_5678);
`endif

        // Reset while an SB sits in its write cycle.
        do_req(1'b0, 1'b1, 3'd2, 32'h30, 32'h1122_3344, "sw30", er, rd, lat);
        req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h31; req_wdata = 32'h77;
        req_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_wr_store_before", 32'(mem_store), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_store_drop", 32'({mem_store, mem_address}), 32'h0);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_ctrl", 32'({req_ready, rsp_done}), 32'h2);
        check("rst_after_rdata", rsp_rdata, 32'h0);
        exp_rdata = 32'h0;
        check("rst_word_kept", ram[12], 32'h1122_3344);
        @(posedge clk); #1;

        for (int r = 0; r < 300; r++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0)      begin ld = 1'b1; st = 1'b1; end
            else if (sel == 1) begin ld = 1'b0; st = 1'b0; end
            else if (sel % 2 == 0) begin ld = 1'b1; st = 1'b0; end
            else               begin ld = 1'b0; st = 1'b1; end
            if ($urandom_range(0, 9) < 8)
                f3 = st ? st_set[$urandom_range(0, 2)] : ld_set[$urandom_range(0, 4)];
            else
                f3 = 3'($urandom_range(0, 7));
            sz = model_size(f3);
            a = 32'h40 + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 9) < 7)
                a = a + 32'(($urandom_range(0, 3) / sz) * sz);
            else
                a = a + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)
                a = a | ($urandom & 32'hFFFF_C000);
            do_req(ld, st, f3, a, $urandom, "rnd", er, rd, lat);
        end

        mism = 0;
        for (int i = 0; i < NWORDS; i++)
            if (ram[i] !== {mbytes[i*4+3], mbytes[i*4+2], mbytes[i*4+1], mbytes[i*4]}) mism++;
        check("mem_final_mismatches", 32'(mism), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
